// File: rtl/seq_mul4_if.sv
// Handshake bundle for seq_mul4: request side (start, a, b) and result side
// (busy, done, product).
interface seq_mul4_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mul4.sv
// Unsigned sequential shift-and-add multiplier: one conditional add and one
// multiplicand doubling per RUN cycle, fixed N-cycle latency.
module seq_mul4 #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_mul4_if.slave   bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  count;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;
  logic [2*N-1:0] acc_sum;

  // Accumulator value after this cycle's conditional add.
  always_comb begin
    acc_sum = acc;
    if (mplier[0]) begin
      acc_sum = acc + mcand;
    end else begin
      acc_sum = acc;
    end
  end

  // Control FSM, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            mcand  <= {{N{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            count  <= CW'(N);
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          busy   <= 1'b1;
          // Last iteration: publish the sum including this cycle's add.
          if (count == CW'(1)) begin
            product <= acc_sum;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            done  <= 1'b0;
            state <= RUN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;
endmodule

// File: doc/seq_mul4.md
SEQ_MUL4 -- requirements
Module: seq_mul4

Interface
REQ-001 Parameter N, default 4, operand width in bits; product width is 2*N.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  N  multiplicand, unsigned, sampled with start.
REQ-006 b  input  N  multiplier, unsigned, sampled with start.
REQ-007 busy  output  1  high while an operation is in progress (states RUN and DONE).
REQ-008 done  output  1  one-cycle pulse marking product valid for the new result.
REQ-009 product  output  2*N  unsigned a*b; holds the last result until the next completion.

Function
REQ-010 The block SHALL implement an unsigned shift-and-add multiplier built from repeated doubling of the multiplicand: one conditional add plus one left-shift-by-1 per cycle.
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE: on a rising edge with start=1, the block SHALL do the following: latch mcand = a zero-extended to 2*N bits; latch mplier = b; clear acc to 0; load count = N; go to RUN.
REQ-013 IDLE with start=0 SHALL remain in IDLE with no register change.
REQ-014 Each RUN edge SHALL perform these steps: if mplier[0]=1 then acc <= acc + mcand (2*N-bit add, no overflow possible); mcand <= mcand << 1 (MSB discarded, zero fill); mplier <= mplier >> 1 (zero fill); count <= count - 1.
REQ-015 On the RUN edge where count=1, the block SHALL load product with the final acc (including that cycle's add) and go to DONE.
REQ-016 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-017 Latency SHALL be fixed and data-independent, with no early termination for zero or small operands:
- start sampled at edge E
- done high during the cycle after edge E+N
- busy low again after edge E+N+1
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE; done SHALL be 1 only in DONE.
REQ-019 start asserted while busy=1 SHALL be ignored; it has no effect on the in-flight operation and is not queued.
REQ-020 start held high continuously SHALL begin a new operation on the first IDLE edge after DONE, i.e. back-to-back throughput of one result per N+2 cycles.
REQ-021 a and b SHALL be don't-care except on the start-sampling edge; changes during RUN SHALL not affect the result.
REQ-022 product SHALL change only on the RUN-to-DONE edge and on reset.

Reset
REQ-023 rst=1 SHALL immediately force the following, independent of clk:
- state=IDLE
- acc, mcand, mplier, count, product all 0
- busy=0, done=0
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse is produced and product reads 0.
REQ-025 The first start after reset deassertion SHALL be honoured on the first rising edge where rst=0.

Verification
REQ-026 Reset then start with a=3, b=5 -> busy=1 from the next cycle; done=1 exactly 4 cycles after the start edge; product=15; busy=0 one cycle later.
REQ-027 Start with a=15, b=15 -> product=225 (8'hE1); then a=0, b=9 -> product=0 with identical 4-cycle latency; then a=8, b=1 -> product=8.
REQ-028 Start with a=6, b=7; pulse start with a=2, b=2 two cycles later -> second start ignored; single done with product=42; no further done.
REQ-029 Start held high with a=12, b=10 -> done pulses every 6 cycles, each with product=120; busy low for exactly one cycle between operations.
REQ-030 Start with a=9, b=9; assert rst asynchronously (between edges) two cycles in -> busy, done and product go to 0 immediately; no done follows.
REQ-031 Randomised sweep of all 256 (a,b) pairs for N=4 -> every product equals a*b and latency is always N cycles from start edge to done.
